// File: rtl/aer_out_scheduler.sv
// AER output scheduler: triggers the sorter, latches the sorted pixel order and emits one
// 4-phase AER event per pixel. Define AER_OUT_EOF_EN to append an all-ones end-of-frame event.
module aer_out_scheduler #(
    parameter int IMAGE_SIZE = 5,
    parameter int ADDR_BITS  = 8
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 start,
    output logic                                 new_image,
    input  logic                                 done,
    input  logic [IMAGE_SIZE-1:0][ADDR_BITS-1:0] sorted_indexes,
    output logic [ADDR_BITS-1:0]                 AERout_ADDR,
    output logic                                 AERout_REQ,
    input  logic                                 AERout_ACK,
    output logic                                 busy,
    output logic                                 frame_done
);

    localparam int CNT_W = $clog2(IMAGE_SIZE + 1);
`ifdef AER_OUT_EOF_EN
    localparam int LAST_EVT = IMAGE_SIZE;
`else
    localparam int LAST_EVT = IMAGE_SIZE - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_EVT);

    typedef enum logic [2:0] {
        StIdle,
        StSort,
        StWaitDone,
        StLatch,
        StSetup,
        StReqHi,
        StAckLo,
        StNext
    } state_e;

    state_e                               r_state;
    logic   [IMAGE_SIZE-1:0][ADDR_BITS-1:0] r_buf;
    logic   [CNT_W-1:0]                   r_cnt;
    logic   [ADDR_BITS-1:0]               r_addr;
    logic                                 r_req;
    logic                                 r_new_image;
    logic                                 r_busy;
    logic                                 r_frame_done;
    logic                                 r_ack_meta;
    logic                                 r_ack_sync;

    logic                                 w_ack;
    logic   [CNT_W-1:0]                   w_cnt_inc;

    assign w_ack     = r_ack_sync;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Address for event idx; the index one past the last pixel is the EOF marker.
    function automatic logic [ADDR_BITS-1:0] f_addr(
        input logic [CNT_W-1:0]                   idx,
        input logic [IMAGE_SIZE-1:0][ADDR_BITS-1:0] bufv
    );
        logic [ADDR_BITS-1:0] v;
        v = '0;
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            if (idx == CNT_W'(i)) v = bufv[i];
        end
`ifdef AER_OUT_EOF_EN
        if (idx == CNT_W'(IMAGE_SIZE)) v = '1;
`endif
        return v;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= StIdle;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_req        <= 1'b0;
            r_new_image  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_ack_meta   <= 1'b0;
            r_ack_sync   <= 1'b0;
        end else begin
            r_ack_meta   <= AERout_ACK;
            r_ack_sync   <= r_ack_meta;
            r_new_image  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_new_image <= 1'b1;
                        r_state     <= StSort;
                    end
                end
                StSort: r_state <= StWaitDone;
                StWaitDone: begin
                    if (done) r_state <= StLatch;
                end
                StLatch: begin
                    // Address is loaded here so it is stable for the whole SETUP phase.
                    r_buf   <= sorted_indexes;
                    r_cnt   <= '0;
                    r_addr  <= sorted_indexes[0];
                    r_state <= StSetup;
                end
                StSetup: begin
                    if (!w_ack) begin
                        r_req   <= 1'b1;
                        r_state <= StReqHi;
                    end
                end
                StReqHi: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_state <= StAckLo;
                    end
                end
                StAckLo: begin
                    if (!w_ack) r_state <= StNext;
                end
                StNext: begin
                    if (r_cnt < LAST_CNT) begin
                        r_cnt   <= w_cnt_inc;
                        r_addr  <= f_addr(w_cnt_inc, r_buf);
                        r_state <= StSetup;
                    end else begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign new_image   = r_new_image;
    assign AERout_ADDR = r_addr;
    assign AERout_REQ  = r_req;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_aer_out_scheduler.sv
// Directed bench for aer_out_scheduler with a delayed 4-phase ACK responder.
// Honours AER_OUT_EOF_EN for the expected event list.
module tb_aer_out_scheduler;

    logic            CLK = 1'b0;
    logic            RST;
    logic            start;
    logic            new_image;
    logic            done;
    logic [4:0][7:0] sorted_indexes;
    logic [7:0]      AERout_ADDR;
    logic            AERout_REQ;
    logic            AERout_ACK;
    logic            busy;
    logic            frame_done;

    int checks = 0;
    int errors = 0;
    int ev_q[$];
    int fd_cnt = 0;
    int ni_cnt = 0;
    logic       prev_req  = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    bit         resp_en   = 1'b0;
    logic       req_seen;

`ifdef AER_OUT_EOF_EN
    localparam int N_EXP = 6;
`else
    localparam int N_EXP = 5;
`endif
    int exp_addr[6] = '{3, 0, 4, 1, 2, 255};

    aer_out_scheduler #(
        .IMAGE_SIZE(5),
        .ADDR_BITS (8)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .new_image     (new_image),
        .done          (done),
        .sorted_indexes(sorted_indexes),
        .AERout_ADDR   (AERout_ADDR),
        .AERout_REQ    (AERout_REQ),
        .AERout_ACK    (AERout_ACK),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Responder: 100 ns from REQ edge to matching ACK edge.
    initial begin
        forever begin
            wait (resp_en && AERout_REQ);
            #100 AERout_ACK = 1'b1;
            wait (!AERout_REQ);
            #100 AERout_ACK = 1'b0;
        end
    end

    // Event monitor sampled 1 ns after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (AERout_REQ && !prev_req) begin
            ev_q.push_back(int'(AERout_ADDR));
            chk("addr_stable_before_req", 32'(AERout_ADDR), 32'(prev_addr));
            chk("ack_low_at_req_rise", 32'(AERout_ACK), 0);
        end else if (AERout_REQ && prev_req) begin
            chk("addr_hold_during_req", 32'(AERout_ADDR), 32'(prev_addr));
        end
        if (frame_done) fd_cnt++;
        if (new_image) ni_cnt++;
        prev_req  = AERout_REQ;
        prev_addr = AERout_ADDR;
    end

    // Caller must be at a falling edge; start is raised immediately.
    task automatic start_frame();
        ev_q.delete();
        fd_cnt = 0;
        ni_cnt = 0;
        chk("new_image_low_before", 32'(new_image), 0);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("new_image_high", 32'(new_image), 1);
        chk("busy_after_start", 32'(busy), 1);
        @(negedge CLK);
        chk("new_image_one_cycle", 32'(new_image), 0);
    endtask

    task automatic pulse_done();
        sorted_indexes = {8'd2, 8'd1, 8'd4, 8'd0, 8'd3};
        done = 1'b1;
        @(negedge CLK);
        done = 1'b0;
        @(negedge CLK);
        sorted_indexes = {8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (fd_cnt > 0) break;
        end
        repeat (5) @(negedge CLK);
        chk("frame_done_pulses", 32'(fd_cnt), 1);
    endtask

    task automatic check_frame();
        chk("event_count", 32'(ev_q.size()), 32'(N_EXP));
        for (int i = 0; i < N_EXP; i++) begin
            if (i < ev_q.size()) chk("event_addr", 32'(ev_q[i]), 32'(exp_addr[i]));
        end
        chk("busy_after_frame", 32'(busy), 0);
        chk("new_image_count", 32'(ni_cnt), 1);
    endtask

    task automatic wait_events(input int n);
        for (int i = 0; i < 3000; i++) begin
            if (ev_q.size() >= n && AERout_REQ) break;
            @(negedge CLK);
        end
        chk("reached_event", 32'(ev_q.size() >= n && AERout_REQ), 1);
    endtask

    initial begin
        RST            = 1'b1;
        start          = 1'b0;
        done           = 1'b0;
        AERout_ACK     = 1'b0;
        sorted_indexes = {8'd2, 8'd1, 8'd4, 8'd0, 8'd3};
        repeat (3) @(negedge CLK);
        chk("rst_req", 32'(AERout_REQ), 0);
        chk("rst_addr", 32'(AERout_ADDR), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_new_image", 32'(new_image), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        RST     = 1'b0;
        resp_en = 1'b1;

        // Frame 1: sorter stalls for 50 cycles, then a normal frame.
        start_frame();
        req_seen = 1'b0;
        repeat (50) begin
            @(negedge CLK);
            if (AERout_REQ) req_seen = 1'b1;
        end
        chk("no_req_while_sorting", 32'(req_seen), 0);
        chk("no_events_while_sorting", 32'(ev_q.size()), 0);
        chk("busy_while_sorting", 32'(busy), 1);
        pulse_done();
        wait_frame();
        check_frame();

        // Frame 2: a second start mid-frame must be ignored.
        start_frame();
        pulse_done();
        wait_events(2);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_frame();
        check_frame();
        repeat (20) @(negedge CLK);
        chk("no_restart_after_ignored", 32'(ni_cnt), 1);
        chk("idle_after_ignored", 32'(busy), 0);

        // Frame 3: ACK stuck high when done arrives.
        resp_en    = 1'b0;
        AERout_ACK = 1'b1;
        @(negedge CLK);
        start_frame();
        pulse_done();
        req_seen = 1'b0;
        repeat (30) begin
            @(negedge CLK);
            if (AERout_REQ) req_seen = 1'b1;
        end
        chk("req_held_while_ack_high", 32'(req_seen), 0);
        AERout_ACK = 1'b0;
        resp_en    = 1'b1;
        wait_frame();
        check_frame();

        // Frame 4: reset during event 2's request, then a clean frame.
        start_frame();
        pulse_done();
        wait_events(2);
        #2 RST = 1'b1;
        #1;
        chk("req_drop_on_rst", 32'(AERout_REQ), 0);
        chk("busy_drop_on_rst", 32'(busy), 0);
        repeat (40) @(negedge CLK);
        chk("no_frame_done_after_rst", 32'(fd_cnt), 0);
        chk("addr_zero_after_rst", 32'(AERout_ADDR), 0);
        RST = 1'b0;
        start_frame();
        pulse_done();
        wait_frame();
        check_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aer_out_scheduler.md
AER_OUT_SCHEDULER -- requirements
Module: aer_out_scheduler

Interface
REQ-001 The block SHALL have parameter IMAGE_SIZE, default 5, number of pixels per image.
REQ-002 The block SHALL have parameter ADDR_BITS, default 8, width of one sorted index and of the AER address.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset; asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to encode and transmit the current image.
REQ-006 The block SHALL have port new_image  output  1  one-cycle start pulse to the sorter.
REQ-007 The block SHALL have port done  input  1  sorter completion flag.
REQ-008 The block SHALL have port sorted_indexes  input  IMAGE_SIZE x ADDR_BITS  pixel indexes in spike order, element 0 first.
REQ-009 The block SHALL have port AERout_ADDR  output  ADDR_BITS  AER event address.
REQ-010 The block SHALL have port AERout_REQ  output  1  AER request, 4-phase.
REQ-011 The block SHALL have port AERout_ACK  input  1  AER acknowledge, asynchronous to CLK.
REQ-012 The block SHALL have port busy  output  1  high from accepted start until frame end.
REQ-013 The block SHALL have port frame_done  output  1  one-cycle pulse after the last event's handshake completes.

Function
REQ-014 The block SHALL pass AERout_ACK through a 2-flop synchronizer; all ACK decisions SHALL use the synchronized value.
REQ-015 The block SHALL implement states IDLE, SORT, WAIT_DONE, LATCH, SETUP, REQ_HI, ACK_LO, NEXT.
REQ-016 In IDLE, start=1 SHALL move to SORT next edge and set busy=1; start while busy SHALL be ignored.
REQ-017 SORT SHALL last exactly one cycle with new_image=1, then go to WAIT_DONE; new_image SHALL be 0 in all other states.
REQ-018 WAIT_DONE SHALL wait for done=1 (done is ignored in every other state), then go to LATCH.
REQ-019 LATCH SHALL copy sorted_indexes into an internal buffer in one cycle and clear the event counter to 0; later changes on sorted_indexes SHALL not affect the frame.
REQ-020 SETUP SHALL drive AERout_ADDR = buffer[counter], stay until synchronized ACK=0, then go to REQ_HI, so the address is stable at least one cycle before REQ rises.
REQ-021 REQ_HI SHALL drive AERout_REQ=1 until synchronized ACK=1, then go to ACK_LO with AERout_REQ=0.
REQ-022 ACK_LO SHALL wait for synchronized ACK=0, then go to NEXT; AERout_ADDR SHALL stay constant from SETUP through ACK_LO.
REQ-023 NEXT SHALL increment the counter and return to SETUP if counter < IMAGE_SIZE-1; otherwise it SHALL pulse frame_done for one cycle, clear busy, and return to IDLE.
REQ-024 The counter width SHALL be clog2(IMAGE_SIZE+1) bits and SHALL never wrap within a frame; exactly IMAGE_SIZE events SHALL be sent per frame (excluding REQ-029).
REQ-025 ACK=1 on entry to SETUP, including the first event, SHALL delay REQ until ACK falls; a REQ edge SHALL never be generated while ACK is high.

Reset
REQ-026 RST=1 SHALL asynchronously force state IDLE, counter 0, buffer 0, synchronizer flops 0, AERout_REQ=0, AERout_ADDR=0, new_image=0, busy=0, frame_done=0.
REQ-027 RST asserted mid-frame or mid-handshake SHALL drop AERout_REQ immediately and abandon the frame with no frame_done pulse.
REQ-028 After RST deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-029 With macro AER_OUT_EOF_EN defined, after the last index the block SHALL send one extra end-of-frame event with AERout_ADDR all ones, using the same handshake, before pulsing frame_done; without it no extra event SHALL be sent and the EOF logic SHALL not exist.

Verification
REQ-030 The bench SHALL check: sorted_indexes={3,0,4,1,2}, ACK responder with 100 ns delays -> events with addresses 3,0,4,1,2 in order, then one frame_done pulse, busy=0.
REQ-031 The bench SHALL check: start pulse -> new_image high exactly one cycle, one cycle after start; done held low 50 cycles -> AERout_REQ stays 0.
REQ-032 The bench SHALL check: AERout_ACK held 1 when done arrives -> AERout_REQ stays 0 until ACK drops, then rises with the address already stable at least one cycle.
REQ-033 The bench SHALL check: RST pulsed while AERout_REQ=1 on event 2 -> REQ=0 at once, no frame_done; a new start then sends all 5 events from index 0.
REQ-034 The bench SHALL check: second start pulse during a frame -> ignored, exactly 5 events and one frame_done.
REQ-035 The bench SHALL check: with AER_OUT_EOF_EN defined -> 6 events, the last with address 0xFF, then frame_done.
